// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back requester encoding used by
// the arbiter and its scoreboard.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_sel_t;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // After a transfer the priority pointer moves to the requester that lost.
    function automatic req_sel_t other_req(input req_sel_t sel);
        return (sel == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker: issue sets a bit, the register-file write
// clears it, and the two source lookups report whether a write is outstanding.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      iss_valid,
    input  reg_addr_t iss_rd,
    input  logic      wr_valid,
    input  reg_addr_t wr_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output logic      rs1_busy,
    output logic      rs2_busy
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    // Clear is applied before set so an issue on the write edge keeps the bit.
    always_comb begin
        pending_next = pending;
        if (wr_valid) begin
            pending_next[wr_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            pending_next[iss_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign rs1_busy = pending[rs1];
    assign rs2_busy = pending[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file write-back arbiter with a registered write port
// and a pending-write scoreboard for source-operand hazard lookup.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [N-1:0]          a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [N-1:0]          b_data,
    output logic                  b_ready,
    output logic                  wb_enable,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [N-1:0]          wb_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    // Handshake: a write moves on a rising edge where valid and ready are both
    // high; the requester holds valid/rd/data until then. Ready is a pure
    // function of this cycle's valids and the pointer, never high without valid.
    req_sel_t                prio_ptr;
    logic                    a_grant;
    logic                    b_grant;
    logic                    xfer;
    req_sel_t                winner;
    logic [REG_ADDR_W-1:0]   sel_rd;
    logic [N-1:0]            sel_data;

    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!rst) begin
            if (a_valid && (!b_valid || (prio_ptr == REQ_A))) begin
                a_grant = 1'b1;
            end else if (b_valid) begin
                b_grant = 1'b1;
            end
        end
    end

    assign a_ready  = a_grant;
    assign b_ready  = b_grant;
    assign xfer     = a_grant | b_grant;
    assign winner   = b_grant ? REQ_B : REQ_A;
    assign sel_rd   = (winner == REQ_B) ? b_rd : a_rd;
    assign sel_data = (winner == REQ_B) ? b_data : a_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_ptr <= REQ_A;
        end else if (xfer) begin
            prio_ptr <= other_req(winner);
        end
    end

    // Writes to x0 still complete the handshake but never strobe the regfile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_enable <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            wb_enable <= xfer && (sel_rd != '0);
            if (xfer) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wr_valid  (wb_enable),
        .wr_rd     (wb_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared with a behavioural arbiter/pending model and an expected-write queue.
module tb_regfile_wb_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, iss_valid;
    logic [4:0]   a_rd, b_rd, iss_rd, rs1, rs2;
    logic [N-1:0] a_data, b_data;
    logic         a_ready, b_ready, wb_enable, rs1_busy, rs2_busy;
    logic [4:0]   wb_rd;
    logic [N-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    logic [N+4:0] exp_q[$];

    // Reference model state
    bit           m_ptr;
    bit           m_pend[32];
    logic         m_wb_en;
    logic [4:0]   m_wb_rd;
    logic [N-1:0] m_wb_data;

    regfile_wb_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Grant rule: {b,a}; lone requester wins, ties go to the pointer.
    function automatic logic [1:0] exp_grant(input logic av, input logic bv, input bit ptr);
        if (av && (!bv || !ptr)) return 2'b01;
        if (bv) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ptr = 1'b0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_wb_en = 1'b0;
        m_wb_rd = '0;
        m_wb_data = '0;
        exp_q.delete();
    endtask

    task automatic model_commit();
        logic [1:0] g;
        g = exp_grant(a_valid, b_valid, m_ptr);
        if (m_wb_en) m_pend[m_wb_rd] = 1'b0;
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
        if (g[0]) begin
            m_wb_en = (a_rd != 0); m_wb_rd = a_rd; m_wb_data = a_data; m_ptr = 1'b1;
        end else if (g[1]) begin
            m_wb_en = (b_rd != 0); m_wb_rd = b_rd; m_wb_data = b_data; m_ptr = 1'b0;
        end else begin
            m_wb_en = 1'b0;
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [N-1:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [N-1:0] bd,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird; rs1 = r1; rs2 = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_commit();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1, 5'd3, 5'd3, 5'd4);
        tick();
        tick();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
        checks++; if ({wb_enable, wb_rd, wb_data} !== '0) begin errors++; $display("FAIL reset_wb: got en=%b rd=%0d data=%0h want 0", wb_enable, wb_rd, wb_data); end
        checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", {rs1_busy, rs2_busy}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] ad, bd;
            ad = 32'hA000_0000 | i;
            bd = 32'hB000_0000 | i;
            drive(1, 5'd1, ad, 1, 5'd2, bd, 0, 0, 0, 0);
            checks++; if ({b_ready, a_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_grant[%0d]: got {b,a}=%b", i, {b_ready, a_ready}); end
            tick();
            checks++; if (wb_data !== ((i % 2 == 0) ? ad : bd) || wb_enable !== 1'b1) begin errors++; $display("FAIL alt_wb[%0d]: got en=%b data=%0h", i, wb_enable, wb_data); end
        end
    endtask

    task automatic test_single_a();
        drive(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({b_ready, a_ready} !== 2'b01) begin errors++; $display("FAIL single_a_ready: got {b,a}=%b want 01", {b_ready, a_ready}); end
        tick();
        checks++; if ({wb_enable, wb_rd, wb_data} !== {1'b1, 5'd5, 32'h1234}) begin errors++; $display("FAIL single_a_wb: got en=%b rd=%0d data=%0h want 1/5/1234", wb_enable, wb_rd, wb_data); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({b_ready, a_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b want 00", {b_ready, a_ready}); end
        tick();
        checks++; if ({wb_enable, wb_rd, wb_data} !== {1'b0, 5'd5, 32'h1234}) begin errors++; $display("FAIL idle_hold: got en=%b rd=%0d data=%0h want 0/5/1234", wb_enable, wb_rd, wb_data); end
    endtask

    task automatic test_rd_zero();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
        tick();
        drive(0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 5'd3, 5'd0);
        checks++; if ({b_ready, a_ready} !== 2'b10) begin errors++; $display("FAIL rd0_ready: got {b,a}=%b want 10", {b_ready, a_ready}); end
        tick();
        checks++; if ({wb_enable, wb_rd, wb_data} !== {1'b0, 5'd0, 32'hFFFF}) begin errors++; $display("FAIL rd0_wb: got en=%b rd=%0d data=%0h want 0/0/ffff", wb_enable, wb_rd, wb_data); end
        tick();
        checks++; if ({rs1_busy, rs2_busy} !== 2'b10) begin errors++; $display("FAIL rd0_pending: got %b want 10", {rs1_busy, rs2_busy}); end
    endtask

    task automatic test_hazard();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL hz_pre: got %b want 0", rs1_busy); end
        tick();
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL hz_set: got %b want 1", rs1_busy); end
        drive(1, 5'd7, 32'h7777, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL hz_a_ready: got %b want 1", a_ready); end
        tick();
        checks++; if ({wb_enable, wb_rd, rs1_busy} !== {1'b1, 5'd7, 1'b1}) begin errors++; $display("FAIL hz_write: got en=%b rd=%0d busy=%b want 1/7/1", wb_enable, wb_rd, rs1_busy); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        tick();
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL hz_clear: got %b want 0", rs1_busy); end
    endtask

    task automatic test_set_clear_same();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9);
        tick();
        drive(1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 5'd0, 5'd9);
        tick();
        checks++; if ({wb_enable, wb_rd} !== {1'b1, 5'd9}) begin errors++; $display("FAIL sc_write: got en=%b rd=%0d want 1/9", wb_enable, wb_rd); end
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9);
        tick();
        checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sc_set_wins: got %b want 1", rs2_busy); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd9);
        tick();
        checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sc_still_set: got %b want 1", rs2_busy); end
        drive(0, 0, 0, 1, 5'd9, 32'h9A, 0, 0, 5'd0, 5'd9);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd9);
        tick();
        checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL sc_cleared: got %b want 0", rs2_busy); end
    endtask

    task automatic test_random();
        logic av = 0, bv = 0, pa = 0, pb = 0, iv;
        logic [4:0] ard = 0, brd = 0, ird, r1, r2;
        logic [N-1:0] ad = 0, bd = 0;
        logic [1:0] g;
        logic [N+4:0] e;
        for (int i = 0; i < 300; i++) begin
            if (!pa) begin av = ($urandom_range(0, 3) != 0); ard = 5'($urandom_range(0, 7)); ad = $urandom; end
            if (!pb) begin bv = ($urandom_range(0, 3) != 0); brd = 5'($urandom_range(0, 7)); bd = $urandom; end
            iv = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            drive(av, ard, ad, bv, brd, bd, iv, ird, r1, r2);
            g = exp_grant(av, bv, m_ptr);
            checks++; if ({b_ready, a_ready} !== g) begin errors++; $display("FAIL rnd_grant[%0d]: got {b,a}=%b want %b", i, {b_ready, a_ready}, g); end
            checks++; if ({rs1_busy, rs2_busy} !== {1'(m_pend[r1]), 1'(m_pend[r2])}) begin errors++; $display("FAIL rnd_busy_pre[%0d]: got %b", i, {rs1_busy, rs2_busy}); end
            if (g[0]) exp_q.push_back({ard, ad});
            if (g[1]) exp_q.push_back({brd, bd});
            pa = av && !g[0];
            pb = bv && !g[1];
            tick();
            checks++; if (wb_enable !== m_wb_en) begin errors++; $display("FAIL rnd_wb_en[%0d]: got %b want %b", i, wb_enable, m_wb_en); end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if ({wb_rd, wb_data} !== e) begin errors++; $display("FAIL rnd_wb[%0d]: got rd=%0d data=%0h want rd=%0d data=%0h", i, wb_rd, wb_data, e[N+4:N], e[N-1:0]); end
            end
            checks++; if ({rs1_busy, rs2_busy} !== {1'(m_pend[r1]), 1'(m_pend[r2])}) begin errors++; $display("FAIL rnd_busy_post[%0d]: got %b", i, {rs1_busy, rs2_busy}); end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 1, 5'd6, 5'd6, 5'd6);
        tick();
        drive(1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 0, 0, 5'd6, 5'd6);
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if ({b_ready, a_ready} !== 2'b00) begin errors++; $display("FAIL mid_ready: got %b want 00", {b_ready, a_ready}); end
        checks++; if ({wb_enable, wb_rd, wb_data} !== '0) begin errors++; $display("FAIL mid_wb: got en=%b rd=%0d data=%0h want 0", wb_enable, wb_rd, wb_data); end
        checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin errors++; $display("FAIL mid_busy: got %b want 00", {rs1_busy, rs2_busy}); end
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({b_ready, a_ready} !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got {b,a}=%b want 01", {b_ready, a_ready}); end
        tick();
        checks++; if ({wb_enable, wb_rd, wb_data} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("FAIL mid_first_wb: got en=%b rd=%0d data=%0h want 1/4/44", wb_enable, wb_rd, wb_data); end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        model_reset();
        test_reset();
        test_alternate();
        test_single_a();
        test_rd_zero();
        test_hazard();
        test_set_clear_same();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
